serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial N-bit subtractor: computes diff = a - b LSB-first, one bit per clock,
//   through a full-subtractor cell built from two half_subtractor instances plus an OR.
//   Sits directly downstream of half_subtractor. Consumes its difference/borrow outputs
//   and turns them into a multi-bit, handshaked, low-area arithmetic stage.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//   clk         in   1      single clock; all state changes on rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      request: sample a/b and begin subtraction
//   a           in   WIDTH  minuend, sampled only on the edge that accepts start
//   b           in   WIDTH  subtrahend, sampled only on the edge that accepts start
//   busy        out  1      high while a subtraction is in progress
//   done        out  1      one-cycle pulse: diff/borrow_out valid
//   diff        out  WIDTH  (a - b) mod 2^WIDTH
//   borrow_out  out  1      1 if a < b (unsigned)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; busy=0, done=0, diff=0, borrow_out=0,
//     internal shift regs, borrow flop and bit counter cleared. Reset mid-operation
//     aborts the operation; no done pulse follows.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE : start=1 -> load a_sh=a, b_sh=b, bq=0, cnt=0; go SHIFT.
//     SHIFT: each edge: d=a_sh[0]^b_sh[0]^bq; bout=(~a_sh[0]&b_sh[0])|(~(a_sh[0]^b_sh[0])&bq);
//            a_sh,b_sh shift right 1; d_sh={d,d_sh[WIDTH-1:1]}; bq=bout; cnt++.
//            On the edge where cnt==WIDTH-1: diff<=final d_sh, borrow_out<=bout; go DONE.
//     DONE : done=1 for this one cycle. start=1 -> reload as in IDLE, go SHIFT
//            (back-to-back supported); else go IDLE.
//   busy=1 exactly in SHIFT. done=1 exactly in DONE.
//   Latency: start sampled on edge E0 -> WIDTH edges in SHIFT -> done high in the
//     cycle after edge E0+WIDTH; throughput one result per WIDTH+1 cycles.
//   start while busy: ignored; operands not resampled; the result is unaffected.
//   diff/borrow_out hold the last result from done until the next done, or reset.
//     They are not updated bit-by-bit on the ports.
//   Arithmetic: unsigned, modulo 2^WIDTH; borrow_out is the borrow out of the MSB.
//   cnt width = $clog2(WIDTH); no wrap beyond WIDTH-1.
// STRUCTURE
//   serial_sub_pkg: state encoding localparams (ST_IDLE=2'd0, ST_SHIFT=2'd1,
//     ST_DONE=2'd2) and the WIDTH legal-range check constants.
//   Sub-module full_subtractor (a, b, bin -> d, bout): two half_subtractor
//     instances with the borrow outputs ORed. It is instantiated once for the
//     serial bit cell.
//   Top level: FSM, counter, operand/result shift registers, borrow flop, output
//     registers.
// TESTING (WIDTH=8 unless stated)
//   a=8'h3C, b=8'h15, start 1 cycle -> busy for 8 cycles, then done pulse;
//     diff=8'h27, borrow_out=0.
//   a=8'h05, b=8'h0A -> diff=8'hFB, borrow_out=1. a=8'h00, b=8'hFF -> diff=8'h01,
//     borrow_out=1. a=b=8'hA5 -> diff=8'h00, borrow_out=0.
//   start held high with new a/b during SHIFT -> ignored; the result matches the
//     first operands. start=1 in the DONE cycle (a=8'h10, b=8'h01) -> immediate
//     SHIFT; next done gives diff=8'h0F.
//   rst_n low on 4th SHIFT cycle -> all outputs 0 immediately (asynchronous);
//     no done pulse; the next start works normally.
//   Random 1000 operand pairs, WIDTH=8 and WIDTH=16 -> {borrow_out,diff} equals the
//     reference model {a<b, a-b}. done is one cycle wide, and done is spaced
//     exactly WIDTH+1 cycles from accepting start.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - state encoding and width limits for the serial subtractor
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - full subtractor from two half subtractors and an OR
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic d0;
  logic b0;
  logic b1;

  half_subtractor u_hs0 (
    .a_i    (a_i),
    .b_i    (b_i),
    .d_o    (d0),
    .bout_o (b0)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_subtractor u_hs1 (
    .a_i    (d0),
    .b_i    (bin_i),
    .d_o    (d_o),
    .bout_o (b1)
  );

  assign bout_o = b0 | b1;

endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - one-bit half subtractor: d = a ^ b, borrow = ~a & b
module half_subtractor (
  input  logic a_i,
  input  logic b_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i;
  assign bout_o = ~a_i & b_i;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first a - b with start/busy/done handshake
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("serial_subtractor: WIDTH out of legal range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             bq_q, bq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             cell_d;
  logic             cell_bout;
  logic             load;
  logic [WIDTH-1:0] d_sh_next;

  full_subtractor u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (bq_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  assign d_sh_next = {cell_d, d_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    bq_d     = bq_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    load     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        load = start;
      end
      S_SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        d_sh_d = d_sh_next;
        bq_d   = cell_bout;
        // Results reach the ports only once the last bit is through the cell.
        if (cnt_q == CNT_LAST) begin
          diff_d   = d_sh_next;
          borrow_d = cell_bout;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        load = start;
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      a_sh_d  = a;
      b_sh_d  = b;
      d_sh_d  = '0;
      bq_d    = 1'b0;
      cnt_d   = '0;
      state_d = S_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      bq_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      bq_q     <= bq_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule
